// File: rtl/entry_exit_detector.sv
// Two-beam gate passage detector: sync + debounce both sensors, then a direction
// FSM that emits one-cycle up/down pulses for completed entries/exits.
module entry_exit_detector #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic up,
    output logic down,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IN1   = 3'd1,
        IN2   = 3'd2,
        IN3   = 3'd3,
        OUT1  = 3'd4,
        OUT2  = 3'd5,
        OUT3  = 3'd6,
        ABORT = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Index 1 = sensor a, index 0 = sensor b, so f_q reads as {fa,fb}.
    logic [1:0]       s1_q, s2_q, f_q, f_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_e state_q, state_d;
    logic   up_d, down_d, busy_d, err_d;

    always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (s2_q[i] == f_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                f_d[i]   = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            f_q      <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            s1_q  <= {a, b};
            s2_q  <= s1_q;
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            up      <= 1'b0;
            down    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            up      <= up_d;
            down    <= down_d;
            busy    <= busy_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  case (f_q)
                       2'b10: state_d = IN1;
                       2'b01: state_d = OUT1;
                       2'b11: state_d = ABORT;
                       default: state_d = IDLE;
                   endcase
            IN1:   case (f_q)
                       2'b00: state_d = IDLE;
                       2'b11: state_d = IN2;
                       2'b01: state_d = ABORT;
                       default: state_d = IN1;
                   endcase
            IN2:   case (f_q)
                       2'b01: state_d = IN3;
                       2'b10: state_d = IN1;
                       2'b00: state_d = ABORT;
                       default: state_d = IN2;
                   endcase
            IN3:   case (f_q)
                       2'b00: state_d = IDLE;
                       2'b11: state_d = IN2;
                       2'b10: state_d = ABORT;
                       default: state_d = IN3;
                   endcase
            OUT1:  case (f_q)
                       2'b00: state_d = IDLE;
                       2'b11: state_d = OUT2;
                       2'b10: state_d = ABORT;
                       default: state_d = OUT1;
                   endcase
            OUT2:  case (f_q)
                       2'b10: state_d = OUT3;
                       2'b01: state_d = OUT1;
                       2'b00: state_d = ABORT;
                       default: state_d = OUT2;
                   endcase
            OUT3:  case (f_q)
                       2'b00: state_d = IDLE;
                       2'b11: state_d = OUT2;
                       2'b01: state_d = ABORT;
                       default: state_d = OUT3;
                   endcase
            ABORT: state_d = (f_q == 2'b00) ? IDLE : ABORT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        up_d   = (state_q == IN3)  && (f_q == 2'b00);
        down_d = (state_q == OUT3) && (f_q == 2'b00);
        err_d  = (state_d == ABORT) && (state_q != ABORT);
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_entry_exit_detector.sv
// Directed bench for entry_exit_detector: stimulus pushes expected pulses
// (kind + cycle) into a queue; a monitor pops and compares on every pulse.
module tb_entry_exit_detector;

    localparam int LAT = 7;  // drive-to-pulse latency in clock edges, DEBOUNCE=4
    localparam int K_UP = 1, K_DOWN = 2, K_ERR = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic up, down, busy, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];

    entry_exit_detector #(.DEBOUNCE(4), .CNT_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .up   (up),
        .down (down),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (reset && (up || down || err)) begin
            int k;
            exp_t e;
            k = up ? K_UP : (down ? K_DOWN : K_ERR);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got kind=%0d (up=%b down=%b err=%b) at cycle %0d, required no pulse",
                         k, up, down, err, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.cyc != cyc || (up && down)) begin
                    failures++;
                    $display("FAIL pulse_match: got kind=%0d cycle=%0d up=%b down=%b, required kind=%0d cycle=%0d",
                             k, cyc, up, down, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Drive {a,b} just after a rising edge, optionally expect a pulse, hold n edges,
    // then check busy.
    task automatic step(input logic va, input logic vb, input int n,
                        input int kind, input logic exp_busy, input string name);
        a = va;
        b = vb;
        if (kind != 0) exp_q.push_back('{kind: kind, cyc: cyc + LAT});
        repeat (n) @(posedge clk);
        #1;
        check(name, {3'b000, busy}, {3'b000, exp_busy});
    endtask

    task automatic entry(input string tag);
        step(1'b1, 1'b0, 10, 0,    1'b1, {tag, "_in1"});
        step(1'b1, 1'b1, 10, 0,    1'b1, {tag, "_in2"});
        step(1'b0, 1'b1, 10, 0,    1'b1, {tag, "_in3"});
        step(1'b0, 1'b0, 10, K_UP, 1'b0, {tag, "_idle"});
    endtask

    initial begin
        logic busy_any;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {up, down, busy, err}, 4'b0000);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_outputs", {up, down, busy, err}, 4'b0000);

        entry("entry");

        step(1'b0, 1'b1, 10, 0,      1'b1, "exit_out1");
        step(1'b1, 1'b1, 10, 0,      1'b1, "exit_out2");
        step(1'b1, 1'b0, 10, 0,      1'b1, "exit_out3");
        step(1'b0, 1'b0, 10, K_DOWN, 1'b0, "exit_idle");

        step(1'b1, 1'b0, 10, 0, 1'b1, "backout_in1");
        step(1'b1, 1'b1, 10, 0, 1'b1, "backout_in2");
        step(1'b1, 1'b0, 10, 0, 1'b1, "backout_in1b");
        step(1'b0, 1'b0, 10, 0, 1'b0, "backout_idle");

        // 3-cycle glitch must never leave IDLE.
        a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a = 1'b0;
        busy_any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            busy_any = busy_any | busy;
        end
        check("glitch3_busy", {3'b000, busy_any}, 4'b0000);
        // 5-cycle pulse reaches IN1 then backs out.
        a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        a = 1'b0;
        busy_any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            busy_any = busy_any | busy;
        end
        check("glitch5_busy_seen", {3'b000, busy_any}, 4'b0001);
        check("glitch5_idle", {3'b000, busy}, 4'b0000);

        step(1'b1, 1'b1, 10, K_ERR, 1'b1, "illegal_abort");
        step(1'b1, 1'b0, 10, 0,     1'b1, "abort_hold");
        step(1'b0, 1'b0, 10, 0,     1'b0, "abort_exit");
        entry("after_abort");

        // Reset while in IN3: passage discarded.
        step(1'b1, 1'b0, 10, 0, 1'b1, "rst_in1");
        step(1'b1, 1'b1, 10, 0, 1'b1, "rst_in2");
        step(1'b0, 1'b1, 10, 0, 1'b1, "rst_in3");
        reset = 1'b0;
        #2;
        check("async_reset_outputs", {up, down, busy, err}, 4'b0000);
        b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("after_reset_idle", {up, down, busy, err}, 4'b0000);
        entry("post_reset_entry");

        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses: got %0d unseen, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget, required completion");
        $fatal(1, "timeout");
    end

endmodule
